// File: rtl/conv_layer_multi_par.sv
// conv_engine: single-filter convolution engine. Every output pixel owns an
//   accumulator; all pixels step through the D*S*S filter taps together, so a
//   full feature map is ready D*S*S cycles after clr is released. The map is
//   held until clr is raised again.
//   Ports: clk, rst (async, active-high), clr (sync clear, holds the engine idle),
//          img (D*H*W words), fil (D*S*S words), res (OH*OW words).
// conv_layer_multi_par: runs K filters on P engines in ceil(K/P) groups behind a
//   start/busy/done handshake. Results land in a registered image one group at a
//   time; the image is cleared when a run is accepted.
//   Ports: clk, rst (async, active-high), start, img, fits (filter k at slice k),
//          busy, done (1-cycle pulse), group_idx, res (map k at slice k).
module conv_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int FLOAT_MODE = 1,
    parameter int D = 1,
    parameter int S = 5,
    parameter int H = 32,
    parameter int W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   clr,
    input  logic [D*H*W*DATA_WIDTH-1:0]            img,
    input  logic [D*S*S*DATA_WIDTH-1:0]            fil,
    output logic [(H-S+1)*(W-S+1)*DATA_WIDTH-1:0]  res
);
    localparam int OH = H - S + 1;
    localparam int OW = W - S + 1;

    // Truncating single-precision helpers; denormals flush to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return '0;
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'd0};
        if (e <= 0) return {a[31] ^ b[31], 31'd0};
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [24:0] mx, my;
        int ex, sh;
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        // x carries the larger magnitude, so its sign is the result sign.
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = int'(x[30:23]);
        sh = ex - int'(y[30:23]);
        mx = {2'b01, x[22:0]};
        my = (sh > 24) ? '0 : ({2'b01, y[22:0]} >> sh);
        if (x[31] == y[31]) begin
            mx = mx + my;
            if (mx[24]) begin
                mx = mx >> 1;
                ex++;
            end
        end else begin
            mx = mx - my;
            if (mx == '0) return '0;
            for (int i = 0; i < 24; i++) begin
                if (!mx[23]) begin
                    mx = mx << 1;
                    ex--;
                end
            end
        end
        if (ex >= 255) return {x[31], 8'hFF, 23'd0};
        if (ex <= 0) return {x[31], 31'd0};
        return {x[31], ex[7:0], mx[22:0]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] mac(input logic [DATA_WIDTH-1:0] acc,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        if (FLOAT_MODE != 0) return fadd(acc, fmul(a, b));
        // Low DATA_WIDTH bits of the product are the same for signed and unsigned.
        return acc + a * b;
    endfunction

    // Tap walker: depth / row / column of the filter tap applied this cycle.
    int td, ti, tj;
    logic active;
    assign active = (td < D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            td <= 0;
            ti <= 0;
            tj <= 0;
        end else if (active) begin
            if (tj == S - 1) begin
                tj <= 0;
                if (ti == S - 1) begin
                    ti <= 0;
                    td <= td + 1;
                end else begin
                    ti <= ti + 1;
                end
            end else begin
                tj <= tj + 1;
            end
        end
    end

    for (genvar gi = 0; gi < OH * OW; gi++) begin : g_pix
        localparam int R = gi / OW;
        localparam int C = gi % OW;
        logic [DATA_WIDTH-1:0] acc_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst || clr)
                acc_reg <= '0;
            else if (active)
                acc_reg <= mac(acc_reg,
                               img[((td * H + R + ti) * W + C + tj) * DATA_WIDTH +: DATA_WIDTH],
                               fil[((td * S + ti) * S + tj) * DATA_WIDTH +: DATA_WIDTH]);
        end
        assign res[gi * DATA_WIDTH +: DATA_WIDTH] = acc_reg;
    end
endmodule

module conv_layer_multi_par #(
    parameter int DATA_WIDTH = 32,
    parameter int FLOAT_MODE = 1,
    parameter int D = 1,
    parameter int S = 5,
    parameter int H = 32,
    parameter int W = 32,
    parameter int K = 6,
    parameter int P = 2,
    parameter int OH = H - S + 1,
    parameter int OW = W - S + 1,
    parameter int ENG_CYCLES = ((OH * OW) / (OH / 2)) * (D * S * S + 3) + 1,
    parameter int G = (K + P - 1) / P
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [D*H*W*DATA_WIDTH-1:0]        img,
    input  logic [K*D*S*S*DATA_WIDTH-1:0]      fits,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(G):0]                 group_idx,
    output logic [K*OH*OW*DATA_WIDTH-1:0]      res
);
    localparam int FW = D * S * S * DATA_WIDTH;
    localparam int MW = OH * OW * DATA_WIDTH;
    localparam int GW = $clog2(G) + 1;
    localparam int CW = $clog2(ENG_CYCLES + 1);

    if (P < 1 || P > K || S > H || S > W || (FLOAT_MODE != 0 && DATA_WIDTH != 32)) begin : g_bad_params
        $error("conv_layer_multi_par: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, FINISH} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [FW-1:0]   fil_reg [P];
    logic [MW-1:0]   eng_res [P];
    logic            eng_clr;

    // Engines are held cleared everywhere except RUN; their maps stay valid
    // through the CAPTURE cycle because the clear only acts at its end.
    assign eng_clr = (state != RUN);

    for (genvar gi = 0; gi < P; gi++) begin : g_eng
        conv_engine #(
            .DATA_WIDTH(DATA_WIDTH), .FLOAT_MODE(FLOAT_MODE),
            .D(D), .S(S), .H(H), .W(W)
        ) u_eng (
            .clk(clk), .rst(rst), .clr(eng_clr),
            .img(img), .fil(fil_reg[gi]), .res(eng_res[gi])
        );
    end

    // busy rises as start is accepted and falls together with done, which is
    // registered on the way out of FINISH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            group_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= '0;
            for (int e = 0; e < P; e++) fil_reg[e] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        res       <= '0;
                        group_idx <= '0;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Engines past the last filter get zeros; their output is dropped.
                    for (int e = 0; e < P; e++) begin
                        if (int'(group_idx) * P + e < K)
                            fil_reg[e] <= fits[(int'(group_idx) * P + e) * FW +: FW];
                        else
                            fil_reg[e] <= '0;
                    end
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (cnt == CW'(ENG_CYCLES - 1))
                        state <= CAPTURE;
                    else
                        cnt <= cnt + 1'b1;
                end
                CAPTURE: begin
                    for (int e = 0; e < P; e++) begin
                        if (int'(group_idx) * P + e < K)
                            res[(int'(group_idx) * P + e) * MW +: MW] <= eng_res[e];
                    end
                    if (group_idx == GW'(G - 1)) begin
                        state <= FINISH;
                    end else begin
                        group_idx <= group_idx + 1'b1;
                        state     <= LOAD;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
